// File: rtl/iob_iob2axi_wr_burst_ctrl_if.sv
// Host job and write-engine control signals of the burst sequencer.
// master: host plus engine feedback side; slave: the sequencer itself.
// Names match the sequencer's port list so waveforms read the same either way.
interface iob_iob2axi_wr_burst_ctrl_if #(
    parameter int ADDR_W    = 32,
    parameter int AXI_LEN_W = 8,
    parameter int CNT_W     = 16
);
    logic                 start_i;
    logic [ADDR_W-1:0]    addr_i;
    logic [CNT_W-1:0]     nwords_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 error_o;
    logic                 run_o;
    logic [ADDR_W-1:0]    eng_addr_o;
    logic [AXI_LEN_W-1:0] eng_length_o;
    logic                 eng_ready_i;
    logic                 eng_error_i;

    modport master (
        output start_i, addr_i, nwords_i, eng_ready_i, eng_error_i,
        input  busy_o, done_o, error_o, run_o, eng_addr_o, eng_length_o
    );

    modport slave (
        input  start_i, addr_i, nwords_i, eng_ready_i, eng_error_i,
        output busy_o, done_o, error_o, run_o, eng_addr_o, eng_length_o
    );
endinterface

// File: rtl/iob_iob2axi_wr_burst_ctrl.sv
// Splits a host write job into AXI INCR bursts (<= MAX_BURST beats, no BOUNDARY crossing).
// Latency: start -> CALC -> ISSUE -> engine -> FINISH; done_o two cycles after start for empty/bad jobs.
// Backpressure: a burst is issued only while eng_ready_i is high; start_i is ignored while busy_o.
module iob_iob2axi_wr_burst_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_LEN_W = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_BURST = 256,
    parameter int BOUNDARY  = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    iob_iob2axi_wr_burst_ctrl_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int PG_W  = $clog2(BOUNDARY);
    localparam int BW    = AXI_LEN_W + 1;
    // Common width wide enough for the remaining count, page beats and MAX_BURST.
    localparam int CW    = CNT_W + BW + PG_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  remaining;
    logic [BW-1:0]     beats;
    logic              err;

    logic [CW-1:0]     page_beats;
    logic [BW-1:0]     calc_beats;
    logic [CNT_W-1:0]  rem_upd;
    logic              err_upd;
    logic              misalign;

    // Burst size: smallest of words left, burst cap and beats left in the current page.
    always_comb begin
        page_beats = (CW'(BOUNDARY) - CW'(cur_addr[PG_W-1:0])) >> BSH;
        calc_beats = BW'(MAX_BURST);
        if (CW'(remaining) < CW'(calc_beats))
            calc_beats = BW'(remaining);
        if (page_beats < CW'(calc_beats))
            calc_beats = BW'(page_beats);
    end

    assign rem_upd  = remaining - CNT_W'(beats);
    assign err_upd  = err | bus.eng_error_i;
    assign misalign = (bus.addr_i & ADDR_W'(BYTES - 1)) != '0;

    // Run strobe follows engine ready while a burst is pending; reset drops it immediately.
    assign bus.run_o = (state == S_ISSUE) && bus.eng_ready_i;

    // Job sequencer with registered host and engine-control outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= S_IDLE;
            cur_addr         <= '0;
            remaining        <= '0;
            beats            <= '0;
            err              <= 1'b0;
            bus.busy_o       <= 1'b0;
            bus.done_o       <= 1'b0;
            bus.error_o      <= 1'b0;
            bus.eng_addr_o   <= '0;
            bus.eng_length_o <= '0;
        end else begin
            bus.done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    // busy_o is still high in the done cycle; it falls here.
                    if (bus.busy_o) begin
                        bus.busy_o <= 1'b0;
                    end else if (bus.start_i) begin
                        cur_addr    <= bus.addr_i;
                        remaining   <= bus.nwords_i;
                        err         <= misalign;
                        bus.error_o <= 1'b0;
                        bus.busy_o  <= 1'b1;
                        state       <= (misalign || bus.nwords_i == '0) ? S_FINISH : S_CALC;
                    end
                end
                S_CALC: begin
                    beats            <= calc_beats;
                    bus.eng_addr_o   <= cur_addr;
                    bus.eng_length_o <= AXI_LEN_W'(calc_beats - BW'(1));
                    state            <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (bus.eng_ready_i)
                        state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (!bus.eng_ready_i)
                        state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.eng_ready_i) begin
                        err       <= err_upd;
                        cur_addr  <= cur_addr + (ADDR_W'(beats) << BSH);
                        remaining <= rem_upd;
                        state     <= (err_upd || rem_upd == '0) ? S_FINISH : S_CALC;
                    end
                end
                S_FINISH: begin
                    bus.done_o  <= 1'b1;
                    bus.error_o <= err;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/iob_iob2axi_wr_burst_ctrl.md
Name: iob_iob2axi_wr_burst_ctrl

Overview:
Sequencer in front of the IOb-to-AXI write engine. It accepts one host write job (start address, total word count) and splits it into legal AXI INCR bursts. Each burst is at most MAX_BURST beats and never crosses a BOUNDARY-byte page. The block drives the engine's run/addr/length control interface, waits for each burst's write response, and reports completion and sticky error to the host.

Parameters:
ADDR_W, 32, byte-address width.
DATA_W, 32, data bus width in bits; DATA_W/8 is a power of 2.
AXI_LEN_W, 8, width of the engine length field (length = beats-1).
CNT_W, 16, width of the job word count.
MAX_BURST, 256, maximum beats per burst; must be <= 2**AXI_LEN_W.
BOUNDARY, 4096, burst page size in bytes (AXI 4 KB rule); power of 2.

Ports:
clk_i  input  1  clock
rst_i  input  1  reset
start_i  input  1  job request; sampled only in IDLE
addr_i  input  ADDR_W  job start byte address
nwords_i  input  CNT_W  job length in DATA_W words
busy_o  output  1  job in progress
done_o  output  1  one-cycle job-complete pulse
error_o  output  1  sticky job error; valid with done_o, cleared on next accepted start
run_o  output  1  engine run strobe
eng_addr_o  output  ADDR_W  burst start address to engine
eng_length_o  output  AXI_LEN_W  burst beats-1 to engine
eng_ready_i  input  1  engine idle (registered ready from the engine)
eng_error_i  input  1  engine burst error (valid when eng_ready_i is high)

Behaviour:
- Clock is clk_i. Reset rst_i is asynchronous and active-high. Everything is synchronous to the rising edge of clk_i.
- Reset values: busy_o=0, done_o=0, error_o=0, run_o=0, eng_addr_o=0, eng_length_o=0. State is IDLE.
- Registers: cur_addr (ADDR_W), remaining (CNT_W), beats (AXI_LEN_W+1 bits), err (sticky).
- IDLE, on start_i=1:
  - Latch addr_i into cur_addr and nwords_i into remaining. Clear err. Set busy_o=1 on the next cycle.
  - If addr_i is not aligned to DATA_W/8, or nwords_i=0, go to FINISH. err is set only for the misaligned case.
  - Otherwise go to CALC.
- CALC (1 cycle):
  - Compute page_beats = (BOUNDARY - cur_addr mod BOUNDARY) / (DATA_W/8).
  - beats = min(remaining, MAX_BURST, page_beats). Registered.
  - eng_addr_o = cur_addr and eng_length_o = beats-1 are registered here and held stable until the next CALC.
  - Go to ISSUE.
- ISSUE:
  - run_o = eng_ready_i (combinational from state).
  - When eng_ready_i=1, run_o pulses for exactly that cycle; go to WAIT_ACK. Otherwise stay.
- WAIT_ACK: wait for eng_ready_i=0, i.e. the engine has accepted the burst, then go to WAIT_DONE. The engine drops ready the cycle after run.
- WAIT_DONE, on eng_ready_i=1:
  - err |= eng_error_i.
  - cur_addr += beats*(DATA_W/8), with ADDR_W wrap. remaining -= beats.
  - If the updated err is 1 or remaining reaches 0, go to FINISH. No further bursts are issued after an error.
  - Otherwise go to CALC.
- FINISH: done_o=1 for 1 cycle; error_o=err; busy_o drops the next cycle; go to IDLE.
- error_o holds its value until the next accepted start, then clears.
- start_i while busy_o=1 is ignored and not queued.
- Minimum job latency, start to done:
  - start cycle, then 1 CALC, ISSUE, ACK, engine time, then 1 FINISH.
  - Empty job (nwords 0): done_o two cycles after start.
- Reset mid-job: the job is abandoned immediately and run_o drops asynchronously. The engine is reset by the same rst_i.

Test Plan:
- DATA_W=32, addr 0x1000, nwords 4 -> one run_o pulse with eng_addr_o=0x1000, eng_length_o=3; then done_o=1, error_o=0, busy_o low.
- addr 0x0, nwords 600 -> three runs: (0x000, 255), (0x400, 255), (0x800, 87); one done_o; error_o=0.
- Page cross: addr 0x0FF0, nwords 10 -> runs (0x0FF0, 3) then (0x1000, 5); no burst crosses 0x1000.
- 600-word job, engine returns eng_error_i=1 after burst 2 -> no third run_o; done_o with error_o=1; next start clears error_o.
- nwords 0 -> done_o two cycles after start, no run_o, error_o=0. addr 0x1002 (misaligned) -> done_o, error_o=1, no run_o.
- start_i pulsed while busy -> ignored. rst_i asserted in WAIT_DONE -> all outputs at reset values in the same cycle; new start afterwards completes normally.
